apb_ram_ws: RTL and testbench

- Parametrised APB4 slave RAM; successor of the fixed 32x32 APB RAM.
- Adds configurable depth and width, byte strobes (pstrb), and programmable wait states.
- Adds a privileged-write region (pprot), misaligned/out-of-range error reporting, and transfer abort handling.
- Sits behind the APB decoder as a scratch/config memory for peripherals.

---
 rtl/apb_ram_ws_if.sv | 26 ++
 rtl/apb_ram_ws.sv | 143 ++++++++++++++
 tb/tb_apb_ram_ws.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_ram_ws_if.sv
// APB4 bus bundle for apb_ram_ws: master drives request fields, slave returns response.
interface apb_ram_ws_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_ws.sv
// apb_ram_ws: parametrised APB4 scratch RAM with byte strobes, programmable wait
// states, a privileged-write low region and error responses for misaligned,
// out-of-range and unprivileged protected writes.
// Optional: define APB_RAM_ERR_COUNT_EN to build the saturating err_count counter;
// otherwise err_count is tied to zero.
module apb_ram_ws #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PROT_WORDS  = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_ram_ws_if.slave      apb,
  output logic [7:0]       err_count
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCNT_W = 4;

  localparam logic [WCNT_W-1:0]     WCNT_MAX = WCNT_W'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] BAD_DATA = {(DATA_WIDTH / 32){32'hDEADBEEF}};

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0]  prdata_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]       idx;
  logic [MEM_AW-1:0]      mem_idx;
  logic                   misaligned, range_err, prot_err, err;
  logic                   setup, ready, err_rsp, wr_en;
  logic                   unused_prot;

  // Address decode and error classification from the live bus fields
  assign idx        = apb.paddr[ADDR_WIDTH-1:LSB];
  assign mem_idx    = MEM_AW'(idx);
  assign misaligned = |apb.paddr[LSB-1:0];
  assign range_err  = 32'(idx) >= DEPTH;
  assign prot_err   = apb.pwrite & (32'(idx) < PROT_WORDS) & ~apb.pprot[0];
  assign err        = misaligned | range_err | prot_err;
  assign unused_prot = ^apb.pprot[2:1];

  // State and wait-counter register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state, wait counting and combinational handshake outputs
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    setup   = apb.psel & ~apb.penable;
    ready   = (state_q == ACCESS) & apb.psel & apb.penable & (wcnt_q == WCNT_MAX);
    err_rsp = ready & err;
    wr_en   = ready & apb.pwrite & ~err;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          wcnt_d  = '0;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          // abort: master dropped select before completion
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (setup) begin
          state_d = ACCESS;
          wcnt_d  = '0;
        end else if (ready) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q != WCNT_MAX) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Read data captured at the setup edge and held until the next setup
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_q <= '0;
    end else if (setup) begin
      prdata_q <= err ? BAD_DATA : mem[mem_idx];
    end
  end

  // Storage array: cleared by reset, byte-lane writes on an error-free completion
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (apb.pstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= apb.pwdata[8*b +: 8];
        end
      end
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = ready;
  assign apb.pslverr = err_rsp;

`ifdef APB_RAM_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of completed transfers that returned an error
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_cnt_q <= '0;
    end else if (err_rsp && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_apb_ram_ws.sv
// Directed bench for apb_ram_ws: three instances (0, 2 and 3 wait states) share one
// request bus; tgt selects which instance sees psel and whose response is observed.
module tb_apb_ram_ws;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [8:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  int          tgt = 0;

  logic [31:0] rd_m;
  logic        rdy_m, err_m;
  logic [7:0]  ec0, ec2, ec3;

  int n_chk = 0;
  int n_err = 0;

`ifdef APB_RAM_ERR_COUNT_EN
  localparam int EC_EXP = 3;
`else
  localparam int EC_EXP = 0;
`endif

  apb_ram_ws_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if0 ();
  apb_ram_ws_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if2 ();
  apb_ram_ws_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if3 ();

  assign if0.psel = psel & (tgt == 0);
  assign if2.psel = psel & (tgt == 2);
  assign if3.psel = psel & (tgt == 3);
  assign if0.penable = penable;  assign if2.penable = penable;  assign if3.penable = penable;
  assign if0.pwrite  = pwrite;   assign if2.pwrite  = pwrite;   assign if3.pwrite  = pwrite;
  assign if0.paddr   = paddr;    assign if2.paddr   = paddr[7:0]; assign if3.paddr = paddr[7:0];
  assign if0.pwdata  = pwdata;   assign if2.pwdata  = pwdata;   assign if3.pwdata  = pwdata;
  assign if0.pstrb   = pstrb;    assign if2.pstrb   = pstrb;    assign if3.pstrb   = pstrb;
  assign if0.pprot   = pprot;    assign if2.pprot   = pprot;    assign if3.pprot   = pprot;

  apb_ram_ws #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0), .PROT_WORDS(4))
    u_ws0 (.pclk(pclk), .presetn(presetn), .apb(if0.slave), .err_count(ec0));
  apb_ram_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(2), .PROT_WORDS(4))
    u_ws2 (.pclk(pclk), .presetn(presetn), .apb(if2.slave), .err_count(ec2));
  apb_ram_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3), .PROT_WORDS(4))
    u_ws3 (.pclk(pclk), .presetn(presetn), .apb(if3.slave), .err_count(ec3));

  always #5 pclk = ~pclk;

  // Response of the currently targeted instance
  always_comb begin
    rd_m  = if0.prdata;
    rdy_m = if0.pready;
    err_m = if0.pslverr;
    if (tgt == 2) begin
      rd_m = if2.prdata; rdy_m = if2.pready; err_m = if2.pslverr;
    end else if (tgt == 3) begin
      rd_m = if3.prdata; rdy_m = if3.pready; err_m = if3.pslverr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One APB transfer; caller is 1 time unit past a rising edge.
  // Returns prdata seen in the first access cycle, prdata and pslverr at completion,
  // and the number of access cycles with pready low.
  task automatic xfer(input int t, input logic wr, input logic [8:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rd_first, output logic [31:0] rd, output logic er,
                      output int ws);
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(posedge pclk); #1;
    penable = 1'b1;
    ws = 0;
    #1;
    rd_first = rd_m;
    while (!rdy_m && ws < 20) begin
      @(posedge pclk); #1;
      ws++;
    end
    if (!rdy_m) check("pready_timeout", 64'(rdy_m), 64'd1);
    rd = rd_m;
    er = err_m;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rf, rd;
    logic er;
    int ws;

    // Reset state
    #12;
    check("rst_prdata", 64'(rd_m), 64'd0);
    check("rst_pready", 64'(rdy_m), 64'd0);
    check("rst_pslverr", 64'(err_m), 64'd0);
    check("rst_errcnt", 64'(ec0), 64'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait write then read
    xfer(0, 1, 9'h010, 32'h11223344, 4'hF, 3'b001, rf, rd, er, ws);
    check("t1_wr_waits", 64'(ws), 64'd0);
    check("t1_wr_err", 64'(er), 64'd0);
    xfer(0, 0, 9'h010, 32'h0, 4'hF, 3'b000, rf, rd, er, ws);
    check("t1_rd_waits", 64'(ws), 64'd0);
    check("t1_rd_data", 64'(rd), 64'h11223344);
    check("t1_rd_err", 64'(er), 64'd0);

    // Byte strobes, including an all-zero strobe
    xfer(0, 1, 9'h040, 32'hAABBCCDD, 4'hF, 3'b001, rf, rd, er, ws);
    xfer(0, 1, 9'h040, 32'h00000000, 4'b0101, 3'b001, rf, rd, er, ws);
    xfer(0, 0, 9'h040, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t3_strb_data", 64'(rd), 64'hAA00CC00);
    xfer(0, 1, 9'h040, 32'hFFFFFFFF, 4'h0, 3'b001, rf, rd, er, ws);
    check("t3_strb0_err", 64'(er), 64'd0);
    xfer(0, 0, 9'h040, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t3_strb0_data", 64'(rd), 64'hAA00CC00);

    // Error responses
    xfer(0, 1, 9'h004, 32'h12345678, 4'hF, 3'b001, rf, rd, er, ws);
    check("t4_priv_wr_err", 64'(er), 64'd0);
    xfer(0, 0, 9'h002, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t4_misal_err", 64'(er), 64'd1);
    check("t4_misal_data", 64'(rd), 64'hDEADBEEF);
    xfer(0, 1, 9'h004, 32'h0, 4'hF, 3'b000, rf, rd, er, ws);
    check("t4_prot_err", 64'(er), 64'd1);
    xfer(0, 0, 9'h004, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t4_prot_keep", 64'(rd), 64'h12345678);
    check("t4_unpriv_rd_err", 64'(er), 64'd0);
    xfer(0, 0, 9'h0FC, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t4_last_word_err", 64'(er), 64'd0);
    check("t4_last_word_data", 64'(rd), 64'd0);
    xfer(0, 0, 9'h100, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t4_range_err", 64'(er), 64'd1);
    check("t4_range_data", 64'(rd), 64'hDEADBEEF);
    check("t4_errcnt", 64'(ec0), 64'(EC_EXP));

    // Three wait states: data stable from the first access cycle
    xfer(3, 1, 9'h020, 32'hCAFEF00D, 4'hF, 3'b001, rf, rd, er, ws);
    check("t2_wr_waits", 64'(ws), 64'd3);
    xfer(3, 0, 9'h020, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t2_rd_waits", 64'(ws), 64'd3);
    check("t2_rd_first", 64'(rf), 64'hCAFEF00D);
    check("t2_rd_data", 64'(rd), 64'hCAFEF00D);

    // Protected-region boundary on the two-wait instance
    xfer(2, 1, 9'h00C, 32'h0, 4'hF, 3'b000, rf, rd, er, ws);
    check("t5_prot_last_err", 64'(er), 64'd1);
    xfer(2, 1, 9'h010, 32'h00000077, 4'hF, 3'b000, rf, rd, er, ws);
    check("t5_prot_above_err", 64'(er), 64'd0);
    xfer(2, 0, 9'h010, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t5_prot_above_data", 64'(rd), 64'h00000077);

    // Abort after one access cycle
    tgt = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 9'h030; pwdata = 32'h55; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    check("t5_abort_rdy0", 64'(rdy_m), 64'd0);
    @(posedge pclk); #1;
    check("t5_abort_rdy1", 64'(rdy_m), 64'd0);
    psel = 1'b0; penable = 1'b0;
    #1;
    check("t5_abort_rdy_drop", 64'(rdy_m), 64'd0);
    @(posedge pclk); #1;
    xfer(2, 0, 9'h030, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t5_after_waits", 64'(ws), 64'd2);
    check("t5_after_data", 64'(rd), 64'd0);
    check("t5_after_err", 64'(er), 64'd0);

    // Reset during a wait cycle of a write
    tgt = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 9'h020; pwdata = 32'h99; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    check("t6_pre_rst_data", 64'(rd_m), 64'hCAFEF00D);
    #2;
    presetn = 1'b0;
    #1;
    check("t6_rst_rdy", 64'(rdy_m), 64'd0);
    check("t6_rst_data", 64'(rd_m), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(3, 0, 9'h020, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t6_word20_clr", 64'(rd), 64'd0);
    xfer(0, 0, 9'h010, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t6_word10_clr", 64'(rd), 64'd0);
    xfer(2, 0, 9'h010, 32'h0, 4'h0, 3'b000, rf, rd, er, ws);
    check("t6_ws2_word10_clr", 64'(rd), 64'd0);
    check("t6_errcnt_clr", 64'({ec0, ec2, ec3}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
